cpu_fetch: RTL

//  Instruction fetch stage of the 16-bit CPU. Reads the instruction pointer from the

---
 rtl/cpu_fetch_if.sv | 28 ++
 rtl/cpu_fetch.sv | 46 ++++
 2 files changed

// File: rtl/cpu_fetch_if.sv
// cpu_fetch_if: IP, instruction-memory and decode signals of the fetch stage.
// master is the fetch stage; slave is the surrounding register file, memory and decode.
interface cpu_fetch_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
);
   logic [ADDR_W-1:0] ip_in;
   logic              ip_write_enable;
   logic [ADDR_W-1:0] ip_next;
   logic              mem_req_valid;
   logic              mem_req_ready;
   logic [ADDR_W-1:0] mem_req_addr;
   logic              mem_resp_valid;
   logic [DATA_W-1:0] mem_resp_data;
   logic              instr_valid;
   logic              instr_ready;
   logic [DATA_W-1:0] instr_data;
   logic [ADDR_W-1:0] instr_addr;
   logic              flush;
   modport master (
      input  ip_in, mem_req_ready, mem_resp_valid, mem_resp_data, instr_ready, flush,
      output ip_write_enable, ip_next, mem_req_valid, mem_req_addr, instr_valid, instr_data, instr_addr
   );
   modport slave (
      output ip_in, mem_req_ready, mem_resp_valid, mem_resp_data, instr_ready, flush,
      input  ip_write_enable, ip_next, mem_req_valid, mem_req_addr, instr_valid, instr_data, instr_addr
   );
endinterface

// File: rtl/cpu_fetch.sv
// cpu_fetch: one-in-flight instruction fetch with decode handshake and IP write-back.
// A flush abandons the current fetch; an outstanding response is drained and dropped.
module cpu_fetch #(
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 16,
   parameter int IP_STEP = 1
) (
   input logic         clock,
   input logic         reset,
   cpu_fetch_if.master bus
);
   typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DRAIN} state_t;
   state_t            state, state_nx;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] data_q;
   always_ff @(posedge clock) begin
      if (reset) begin
         state  <= IDLE;
         addr_q <= '0;
         data_q <= '0;
      end else begin
         state <= state_nx;
         if (state == REQ && bus.mem_req_ready) addr_q <= bus.ip_in;
         if (state == WAIT && bus.mem_resp_valid && !bus.flush) data_q <= bus.mem_resp_data;
      end
   end
   always_comb begin
      state_nx            = state;
      bus.mem_req_valid   = state == REQ;
      bus.mem_req_addr    = state == REQ ? bus.ip_in : '0;
      bus.instr_valid     = state == HOLD;
      bus.instr_data      = data_q;
      bus.instr_addr      = addr_q;
      bus.ip_write_enable = state == HOLD && bus.instr_ready && !bus.flush;
      bus.ip_next         = state == HOLD ? addr_q + ADDR_W'(IP_STEP) : '0;
      case (state)
         IDLE:    state_nx = REQ;
         REQ:     state_nx = bus.mem_req_ready ? (bus.flush ? DRAIN : WAIT) : REQ;
         // a response coinciding with flush is already gone, so nothing to drain
         WAIT:    state_nx = bus.flush ? (bus.mem_resp_valid ? REQ : DRAIN) : (bus.mem_resp_valid ? HOLD : WAIT);
         HOLD:    state_nx = (bus.flush || bus.instr_ready) ? REQ : HOLD;
         DRAIN:   state_nx = bus.mem_resp_valid ? REQ : DRAIN;
         default: state_nx = IDLE;
      endcase
   end
endmodule
